sdram_resp_model: RTL and testbench
===================================

// Module: sdram_resp_model
// PURPOSE
//  Responder end of the SDRAM command interface: decodes {CS_N,RAS_N,CAS_N,WE_N}
//  from the controller, tracks per-bank open rows, stores write bursts, and returns
//  read bursts after the programmed CAS latency. Synthesizable with a split DQ bus.
//  Used as the device side in controller benches and FPGA loopback builds.
//  Flags protocol violations and counts refreshes for checking.
// PARAMETERS
//  MEM_ROW_BITS  4    row bits actually stored per bank (low bits of the ACT row)
//  COL_BITS      9    column bits (A[8:0])
//  CL_DEFAULT    3    CAS latency used until the first MRS
//  BL_DEFAULT    4    burst length used until the first MRS
// PORTS
//  clk          in   1   single clock; DRAM commands are sampled on its rising edge
//  rst          in   1   synchronous, active-high reset
//  DRAM_CKE     in   1   0 = all command inputs ignored (treated as NOP), state frozen
//  DRAM_CS_N    in   1   chip select, active low
//  DRAM_RAS_N   in   1   command bit
//  DRAM_CAS_N   in   1   command bit
//  DRAM_WE_N    in   1   command bit
//  DRAM_BA      in   2   bank address
//  DRAM_ADDR    in   13  row (ACT), column + A10 (RD/WR/PRE), mode (MRS)
//  DRAM_DQM     in   2   byte mask; 1 = byte not written / read beat driven as 0
//  dq_i         in   16  write data from the controller
//  dq_o         out  16  read data to the controller
//  dq_oe        out  1   1 = model drives DQ (read beat valid)
//  err_valid    out  1   one-cycle pulse on a protocol violation
//  err_code     out  3   1 = RD/WR to idle bank, 2 = ACT to open bank,
//                        3 = AREF with any bank open, 4 = RD/WR before MRS
//  aref_cnt     out  16  number of accepted AREF commands; wraps at 0xFFFF
// BEHAVIOUR
//  Reset: all banks IDLE; mode_set=0; CL=CL_DEFAULT; BL=BL_DEFAULT; bursts cancelled;
//   dq_o=0, dq_oe=0, err_valid=0, err_code=0, aref_cnt=0. Memory contents are not cleared.
//  Decode {CS,RAS,CAS,WE}: 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE,
//   0001 AREF, 0000 MRS, 0110 BST. CS_N=1 is DESELECT (= NOP).
//  Bank FSM (x4): IDLE -ACT-> ACTIVE(row latched) -PRE (BA match or A10=1)-> IDLE.
//  MRS: only when all banks are IDLE, otherwise ignored. BL = 1,2,4,8 for A[2:0] = 0..3;
//   other codes give BL=8. CL = 2 or 3 from A[6:4]; other codes give 3. Sets mode_set=1.
//  WRITE: beat 0 is taken from dq_i in the command cycle. Beats 1..BL-1 follow on the
//   next cycles. Column increments and wraps inside the BL-aligned block (sequential).
//   DQM[0]/DQM[1] mask the low/high byte of each beat.
//  READ: beat 0 appears with dq_oe=1 exactly CL cycles after the command edge.
//   Then BL consecutive beats; dq_o = mem or 0 for a masked byte. dq_oe=0 otherwise.
//  Address = {BA, open_row[MEM_ROW_BITS-1:0], col}; bank row captured at RD/WR issue.
//  A new READ or WRITE terminates the burst in progress on its issue cycle.
//  BST terminates the current burst: no write beats after it, and no read beats issued
//   after it (beats already inside the CL pipeline still appear).
//  PRE to the bank of an active write burst ends that burst the same cycle.
//  Errored command: not executed; err_valid=1 the next cycle with its code.
//  Simultaneous errors are impossible (one command per cycle).
//  AREF accepted only when all banks are IDLE; aref_cnt increments.
//  rst mid-burst: burst dropped, dq_oe=0 on the next edge.
// TESTING
//  MRS A=0x032, ACT b0 r5, WRITE c=0x004 data 0x1111..0x4444, READ c=0x004 ->
//   dq_oe high 3 cycles after READ, beats 0x1111,0x2222,0x3333,0x4444.
//  BL=4, WRITE at c=0x006 -> data stored at cols 6,7,4,5 (block wrap).
//  READ to idle bank 2 -> err_valid pulse with err_code=1, dq_oe stays 0.
//  AREF with bank 1 open -> err_code=3, aref_cnt unchanged; after PRE A10=1, AREF -> aref_cnt=1.
//  WRITE with DQM=2'b10 data 0xABCD over 0xFFFF -> readback 0xFFCD;
//   BST after 2 read beats at CL=2 -> exactly 2+2 beats seen.
//  DRAM_CKE=0 during a READ command -> no dq_oe activity; rst during read burst -> dq_oe=0 next cycle.

Source files
------------

// File: rtl/sdram_resp_model.sv
// Device-side SDRAM responder: decodes controller commands, tracks per-bank open rows,
// stores write bursts and returns read bursts after the programmed CAS latency.
module sdram_resp_model #(
    parameter int MEM_ROW_BITS = 4,
    parameter int COL_BITS     = 9,
    parameter int CL_DEFAULT   = 3,
    parameter int BL_DEFAULT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DRAM_CKE,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic [1:0]  DRAM_BA,
    input  logic [12:0] DRAM_ADDR,
    input  logic [1:0]  DRAM_DQM,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [15:0] aref_cnt
);

    localparam int AW = 2 + MEM_ROW_BITS + COL_BITS;

    typedef enum logic [3:0] {
        CMD_MRS   = 4'b0000, CMD_AREF = 4'b0001, CMD_PRE = 4'b0010, CMD_ACT = 4'b0011,
        CMD_WRITE = 4'b0100, CMD_READ = 4'b0101, CMD_BST = 4'b0110, CMD_NOP = 4'b0111
    } cmd_t;

    typedef enum logic {BANK_IDLE = 1'b0, BANK_ACTIVE = 1'b1} bank_state_t;

    // Sequential burst order: the offset wraps inside the BL-aligned column block.
    function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] start,
                                                      input logic [3:0] cnt,
                                                      input logic [3:0] bl);
        logic [COL_BITS-1:0] m;
        m = {{(COL_BITS-4){1'b0}}, (bl - 4'd1)};
        return (start & ~m) | ((start + {{(COL_BITS-4){1'b0}}, cnt}) & m);
    endfunction

    logic [15:0]             mem_r [0:(1<<AW)-1];
    logic [15:0]             mem_rd_r;
    bank_state_t             bank_state_r [4];
    logic [MEM_ROW_BITS-1:0] bank_row_r [4];
    logic                    mode_set_r;
    logic [1:0]              cl_r;
    logic [3:0]              bl_r;
    logic                    rd_active_r, wr_active_r;
    logic [1:0]              rd_bank_r, wr_bank_r;
    logic [MEM_ROW_BITS-1:0] rd_row_r, wr_row_r;
    logic [COL_BITS-1:0]     rd_col_r, wr_col_r;
    logic [3:0]              rd_cnt_r, wr_cnt_r;
    logic                    p1_valid_r, p2_valid_r, p3_valid_r;
    logic [AW-1:0]           p1_addr_r;
    logic [1:0]              p1_mask_r, p2_mask_r;
    logic [15:0]             p3_data_r;

    cmd_t          cmd_s;
    logic          bank_busy_s, any_open_s;
    logic [2:0]    err_code_s;
    logic          rd_start_s, wr_start_s, rd_cut_s, wr_cut_s;
    logic          rd_issue_s, wr_en_s;
    logic [AW-1:0] rd_addr_s, wr_addr_s;
    logic [1:0]    rd_mask_s, wr_mask_s;
    logic [15:0]   wr_data_s, p2_data_s;
    logic          unused_s;

    assign unused_s = ^{DRAM_ADDR[12:11], DRAM_ADDR[9]};

    // Command decode and protocol check; CKE low or deselect reads as NOP.
    always_comb begin
        cmd_s       = CMD_NOP;
        any_open_s  = 1'b0;
        err_code_s  = 3'd0;
        if (DRAM_CKE && !DRAM_CS_N) begin
            cmd_s = cmd_t'({1'b0, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N});
        end else begin
            cmd_s = CMD_NOP;
        end
        for (int b = 0; b < 4; b++) begin
            any_open_s = any_open_s | (bank_state_r[b] == BANK_ACTIVE);
        end
        bank_busy_s = (bank_state_r[DRAM_BA] == BANK_ACTIVE);
        case (cmd_s)
            CMD_READ, CMD_WRITE: begin
                if (!mode_set_r)       err_code_s = 3'd4;
                else if (!bank_busy_s) err_code_s = 3'd1;
                else                   err_code_s = 3'd0;
            end
            CMD_ACT:  err_code_s = bank_busy_s ? 3'd2 : 3'd0;
            CMD_AREF: err_code_s = any_open_s ? 3'd3 : 3'd0;
            default:  err_code_s = 3'd0;
        endcase
        rd_start_s = (cmd_s == CMD_READ)  && (err_code_s == 3'd0);
        wr_start_s = (cmd_s == CMD_WRITE) && (err_code_s == 3'd0);
        rd_cut_s   = (cmd_s == CMD_BST) || wr_start_s;
        wr_cut_s   = (cmd_s == CMD_BST) || rd_start_s ||
                     ((cmd_s == CMD_PRE) && (DRAM_ADDR[10] || (DRAM_BA == wr_bank_r)));
    end

    // Beat issue for both burst engines; a frozen clock (CKE low) stalls them.
    always_comb begin
        rd_issue_s = 1'b0;
        rd_addr_s  = '0;
        rd_mask_s  = DRAM_DQM;
        wr_en_s    = 1'b0;
        wr_addr_s  = '0;
        wr_mask_s  = DRAM_DQM;
        wr_data_s  = dq_i;
        if (rd_start_s) begin
            rd_issue_s = 1'b1;
            rd_addr_s  = {DRAM_BA, bank_row_r[DRAM_BA], DRAM_ADDR[COL_BITS-1:0]};
        end else if (rd_active_r && DRAM_CKE && !rd_cut_s) begin
            rd_issue_s = 1'b1;
            rd_addr_s  = {rd_bank_r, rd_row_r, burst_col(rd_col_r, rd_cnt_r, bl_r)};
        end else begin
            rd_issue_s = 1'b0;
        end
        if (wr_start_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = {DRAM_BA, bank_row_r[DRAM_BA], DRAM_ADDR[COL_BITS-1:0]};
        end else if (wr_active_r && DRAM_CKE && !wr_cut_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = {wr_bank_r, wr_row_r, burst_col(wr_col_r, wr_cnt_r, bl_r)};
        end else begin
            wr_en_s = 1'b0;
        end
        p2_data_s = {p2_mask_r[1] ? 8'h00 : mem_rd_r[15:8],
                     p2_mask_r[0] ? 8'h00 : mem_rd_r[7:0]};
    end

    // Storage array with byte-masked writes and a registered read port.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            if (!wr_mask_s[0]) mem_r[wr_addr_s][7:0]  <= wr_data_s[7:0];
            if (!wr_mask_s[1]) mem_r[wr_addr_s][15:8] <= wr_data_s[15:8];
        end
        mem_rd_r <= mem_r[p1_addr_r];
    end

    // Bank FSMs, mode register, burst engines, read latency pipeline and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                bank_state_r[b] <= BANK_IDLE;
                bank_row_r[b]   <= '0;
            end
            mode_set_r  <= 1'b0;
            cl_r        <= 2'(CL_DEFAULT);
            bl_r        <= 4'(BL_DEFAULT);
            rd_active_r <= 1'b0;  wr_active_r <= 1'b0;
            rd_bank_r   <= 2'd0;  wr_bank_r   <= 2'd0;
            rd_row_r    <= '0;    wr_row_r    <= '0;
            rd_col_r    <= '0;    wr_col_r    <= '0;
            rd_cnt_r    <= 4'd0;  wr_cnt_r    <= 4'd0;
            p1_valid_r  <= 1'b0;  p2_valid_r  <= 1'b0;  p3_valid_r <= 1'b0;
            p1_addr_r   <= '0;
            p1_mask_r   <= 2'b00; p2_mask_r   <= 2'b00;
            p3_data_r   <= 16'h0000;
            dq_o        <= 16'h0000;
            dq_oe       <= 1'b0;
            err_valid   <= 1'b0;
            err_code    <= 3'd0;
            aref_cnt    <= 16'h0000;
        end else begin
            for (int b = 0; b < 4; b++) begin
                case (bank_state_r[b])
                    BANK_IDLE: begin
                        if ((cmd_s == CMD_ACT) && (err_code_s == 3'd0) && (DRAM_BA == 2'(b))) begin
                            bank_state_r[b] <= BANK_ACTIVE;
                            bank_row_r[b]   <= DRAM_ADDR[MEM_ROW_BITS-1:0];
                        end
                    end
                    BANK_ACTIVE: begin
                        if ((cmd_s == CMD_PRE) && (DRAM_ADDR[10] || (DRAM_BA == 2'(b)))) begin
                            bank_state_r[b] <= BANK_IDLE;
                        end
                    end
                    default: bank_state_r[b] <= BANK_IDLE;
                endcase
            end
            if ((cmd_s == CMD_MRS) && !any_open_s) begin
                mode_set_r <= 1'b1;
                case (DRAM_ADDR[2:0])
                    3'd0:    bl_r <= 4'd1;
                    3'd1:    bl_r <= 4'd2;
                    3'd2:    bl_r <= 4'd4;
                    default: bl_r <= 4'd8;
                endcase
                cl_r <= (DRAM_ADDR[6:4] == 3'd2) ? 2'd2 : 2'd3;
            end
            if (rd_start_s) begin
                rd_active_r <= (bl_r != 4'd1);
                rd_bank_r   <= DRAM_BA;
                rd_row_r    <= bank_row_r[DRAM_BA];
                rd_col_r    <= DRAM_ADDR[COL_BITS-1:0];
                rd_cnt_r    <= 4'd1;
            end else if (rd_cut_s) begin
                rd_active_r <= 1'b0;
            end else if (rd_issue_s) begin
                rd_cnt_r <= rd_cnt_r + 4'd1;
                if (rd_cnt_r == bl_r - 4'd1) rd_active_r <= 1'b0;
            end
            if (wr_start_s) begin
                wr_active_r <= (bl_r != 4'd1);
                wr_bank_r   <= DRAM_BA;
                wr_row_r    <= bank_row_r[DRAM_BA];
                wr_col_r    <= DRAM_ADDR[COL_BITS-1:0];
                wr_cnt_r    <= 4'd1;
            end else if (wr_cut_s) begin
                wr_active_r <= 1'b0;
            end else if (wr_en_s) begin
                wr_cnt_r <= wr_cnt_r + 4'd1;
                if (wr_cnt_r == bl_r - 4'd1) wr_active_r <= 1'b0;
            end
            if ((cmd_s == CMD_AREF) && (err_code_s == 3'd0)) begin
                aref_cnt <= aref_cnt + 16'd1;
            end
            // Stage 1 holds the beat address, stage 2 the array data, stage 3 adds a cycle for CL=3.
            p1_valid_r <= rd_issue_s;
            p1_addr_r  <= rd_addr_s;
            p1_mask_r  <= rd_mask_s;
            p2_valid_r <= p1_valid_r;
            p2_mask_r  <= p1_mask_r;
            p3_valid_r <= p2_valid_r;
            p3_data_r  <= p2_valid_r ? p2_data_s : 16'h0000;
            if (cl_r == 2'd2) begin
                dq_oe <= p2_valid_r;
                dq_o  <= p2_valid_r ? p2_data_s : 16'h0000;
            end else begin
                dq_oe <= p3_valid_r;
                dq_o  <= p3_data_r;
            end
            err_valid <= (err_code_s != 3'd0);
            err_code  <= err_code_s;
        end
    end

endmodule

// File: tb/tb_sdram_resp_model.sv
// Directed bench for sdram_resp_model: mode set, write/read bursts, block wrap,
// protocol errors, refresh counting, byte masking, burst stop, CKE and reset.
module tb_sdram_resp_model;

    localparam logic [3:0] C_MRS   = 4'b0000;
    localparam logic [3:0] C_AREF  = 4'b0001;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_READ  = 4'b0101;
    localparam logic [3:0] C_BST   = 4'b0110;
    localparam logic [3:0] C_NOP   = 4'b0111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b1;
    logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = 2'd0;
    logic [12:0] addr = 13'h0000;
    logic [1:0]  dqm = 2'b00;
    logic [15:0] dq_i = 16'h0000;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [15:0] aref_cnt;

    int total = 0;
    int bad = 0;

    sdram_resp_model dut (
        .clk(clk), .rst(rst), .DRAM_CKE(cke), .DRAM_CS_N(cs_n), .DRAM_RAS_N(ras_n),
        .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n), .DRAM_BA(ba), .DRAM_ADDR(addr),
        .DRAM_DQM(dqm), .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe),
        .err_valid(err_valid), .err_code(err_code), .aref_cnt(aref_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for one edge, then fall back to NOP; returns 1 ns after that edge.
    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [1:0] m, input logic [15:0] d);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b; addr = a; dqm = m; dq_i = d;
        step();
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        dqm = 2'b00; dq_i = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total += 5;
        if (dq_oe !== 1'b0)       begin bad++; $display("FAIL reset_oe got %b want 0", dq_oe); end
        if (dq_o !== 16'h0000)    begin bad++; $display("FAIL reset_dq got %h want 0000", dq_o); end
        if (err_valid !== 1'b0)   begin bad++; $display("FAIL reset_errv got %b want 0", err_valid); end
        if (err_code !== 3'd0)    begin bad++; $display("FAIL reset_code got %0d want 0", err_code); end
        if (aref_cnt !== 16'h0)   begin bad++; $display("FAIL reset_aref got %0d want 0", aref_cnt); end
        rst = 1'b0;
        step();
    endtask

    task automatic read_check(input string name, input logic [1:0] b, input logic [12:0] a,
                              input int cl, input logic [15:0] exp [4]);
        logic exp_oe;
        drive(C_READ, b, a, 2'b00, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            exp_oe = (i >= cl) && (i < cl + 4);
            total++;
            if (dq_oe !== exp_oe) begin
                bad++; $display("FAIL %s_oe[%0d] got %b want %b", name, i, dq_oe, exp_oe);
            end
            if (exp_oe) begin
                total++;
                if (dq_o !== exp[i-cl]) begin
                    bad++; $display("FAIL %s_data[%0d] got %h want %h", name, i - cl, dq_o, exp[i-cl]);
                end
            end
            step();
        end
    endtask

    task automatic test_write_read();
        logic [15:0] exp [4];
        exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        drive(C_MRS, 2'd0, 13'h032, 2'b00, 16'h0000);
        drive(C_ACT, 2'd0, 13'h005, 2'b00, 16'h0000);
        drive(C_WRITE, 2'd0, 13'h004, 2'b00, 16'h1111);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h2222);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h3333);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'h4444);
        read_check("cl3_read", 2'd0, 13'h004, 3, exp);
    endtask

    task automatic test_block_wrap();
        logic [15:0] exp [4];
        exp = '{16'hA002, 16'hA003, 16'hA000, 16'hA001};
        drive(C_WRITE, 2'd0, 13'h006, 2'b00, 16'hA000);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'hA001);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'hA002);
        drive(C_NOP, 2'd0, 13'h000, 2'b00, 16'hA003);
        read_check("wrap", 2'd0, 13'h004, 3, exp);
    endtask

    task automatic test_err_idle();
        drive(C_READ, 2'd2, 13'h000, 2'b00, 16'h0000);
        total += 2;
        if (err_valid !== 1'b1) begin bad++; $display("FAIL idle_errv got %b want 1", err_valid); end
        if (err_code !== 3'd1)  begin bad++; $display("FAIL idle_code got %0d want 1", err_code); end
        step();
        total++;
        if (err_valid !== 1'b0) begin bad++; $display("FAIL idle_pulse got %b want 0", err_valid); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (dq_oe !== 1'b0) begin bad++; $display("FAIL idle_oe[%0d] got %b want 0", i, dq_oe); end
            step();
        end
    endtask

    task automatic test_act_aref();
        drive(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0000);
        total++;
        if (err_valid !== 1'b0) begin bad++; $display("FAIL act_ok got %b want 0", err_valid); end
        drive(C_ACT, 2'd1, 13'h003, 2'b00, 16'h0000);
        total += 2;
        if (err_valid !== 1'b1) begin bad++; $display("FAIL act_open_errv got %b want 1", err_valid); end
        if (err_code !== 3'd2)  begin bad++; $display("FAIL act_open_code got %0d want 2", err_code); end
        drive(C_AREF, 2'd0, 13'h000, 2'b00, 16'h0000);
        total += 3;
        if (err_valid !== 1'b1)  begin bad++; $display("FAIL aref_open_errv got %b want 1", err_valid); end
        if (err_code !== 3'd3)   begin bad++; $display("FAIL aref_open_code got %0d want 3", err_code); end
        if (aref_cnt !== 16'd0)  begin bad++; $display("FAIL aref_open_cnt got %0d want 0", aref_cnt); end
        drive(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0000);
        drive(C_AREF, 2'd0, 13'h000, 2'b00, 16'h0000);
        total += 2;
        if (err_valid !== 1'b0)  begin bad++; $display("FAIL aref_ok_errv got %b want 0", err_valid); end
        if (aref_cnt !== 16'd1)  begin bad++; $display("FAIL aref_ok_cnt got %0d want 1", aref_cnt); end
    endtask

    task automatic test_dqm_bst();
        int beats;
        drive(C_MRS, 2'd0, 13'h023, 2'b00, 16'h0000);
        drive(C_ACT, 2'd3, 13'h009, 2'b00, 16'h0000);
        drive(C_WRITE, 2'd3, 13'h010, 2'b00, 16'hFFFF);
        drive(C_BST, 2'd0, 13'h000, 2'b00, 16'h0000);
        drive(C_WRITE, 2'd3, 13'h010, 2'b10, 16'hABCD);
        drive(C_BST, 2'd0, 13'h000, 2'b00, 16'h0000);
        drive(C_READ, 2'd3, 13'h010, 2'b00, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (dq_oe !== 1'b0) begin bad++; $display("FAIL cl2_lead_oe[%0d] got %b want 0", i, dq_oe); end
            step();
        end
        total += 2;
        if (dq_oe !== 1'b1)      begin bad++; $display("FAIL cl2_first_oe got %b want 1", dq_oe); end
        if (dq_o !== 16'hFFCD)   begin bad++; $display("FAIL dqm_data got %h want ffcd", dq_o); end
        step();
        total++;
        if (dq_oe !== 1'b1)      begin bad++; $display("FAIL cl2_second_oe got %b want 1", dq_oe); end
        drive(C_BST, 2'd0, 13'h000, 2'b00, 16'h0000);
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            beats += (dq_oe === 1'b1) ? 1 : 0;
            step();
        end
        total++;
        if (beats != 2) begin bad++; $display("FAIL bst_tail_beats got %0d want 2", beats); end
    endtask

    task automatic test_cke();
        cke = 1'b0;
        drive(C_READ, 2'd3, 13'h010, 2'b00, 16'h0000);
        cke = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (dq_oe !== 1'b0) begin bad++; $display("FAIL cke_oe[%0d] got %b want 0", i, dq_oe); end
            step();
        end
    endtask

    task automatic test_rst_mid();
        drive(C_READ, 2'd3, 13'h010, 2'b00, 16'h0000);
        step(); step();
        total++;
        if (dq_oe !== 1'b1) begin bad++; $display("FAIL rst_pre_oe got %b want 1", dq_oe); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (dq_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_oe got %b want 0", dq_oe); end
        step();
        total += 2;
        if (dq_oe !== 1'b0)     begin bad++; $display("FAIL rst_after_oe got %b want 0", dq_oe); end
        if (aref_cnt !== 16'd0) begin bad++; $display("FAIL rst_aref got %0d want 0", aref_cnt); end
        drive(C_READ, 2'd0, 13'h000, 2'b00, 16'h0000);
        total += 2;
        if (err_valid !== 1'b1) begin bad++; $display("FAIL no_mrs_errv got %b want 1", err_valid); end
        if (err_code !== 3'd4)  begin bad++; $display("FAIL no_mrs_code got %0d want 4", err_code); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_block_wrap();
        test_err_idle();
        test_act_aref();
        test_dqm_bst();
        test_cke();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
